bcd_serial_addsub: RTL and testbench

//  Multi-digit packed-BCD adder/subtractor.
//  - Processes one decimal digit per clock, least-significant digit first.
//  - Uses a single 1-digit BCD add stage with a +6 correction.
//  - Replaces the fixed single-digit combinational BCD adder wherever wide decimal operands are needed.
//  - Uses a start/busy/done handshake so that a controller or counter chain can sequence it.

---
 rtl/bcd_serial_addsub.sv | 168 ++++++++++++++++
 tb/tb_bcd_serial_addsub.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_addsub.sv
// Serial packed-BCD adder/subtractor: one decimal digit per clock, LSD first, through one +6-corrected digit stage.
// Digit 0 is taken from the live operands on the start edge, so done follows start by DIGITS cycles.
module bcd_serial_addsub #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  sub,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   result,
    output logic                  carry,
    output logic                  err
);

    localparam int            IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [4*DIGITS-1:0] a_q;
    logic [4*DIGITS-1:0] b_q;
    logic                sub_q;
    logic [IW-1:0]       idx;
    logic                c_q;

    logic                step;
    logic                fin;
    logic                bad_start;
    logic                bad_ops;
    logic [IW-1:0]       wr_idx;
    logic [3:0]          dig_a;
    logic [3:0]          dig_b;
    logic [3:0]          dig_bp;
    logic                sub_eff;
    logic                c_in;
    logic [4:0]          s;
    logic [4:0]          s_fix;
    logic [3:0]          dsum;
    logic                cout;

    function automatic logic has_bad_digit(input logic [4*DIGITS-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    assign bad_ops = has_bad_digit(a) | has_bad_digit(b);

    // In IDLE the stage works on digit 0 of the live inputs; in RUN on the latched copy.
    always_comb begin
        wr_idx  = '0;
        dig_a   = a[3:0];
        dig_b   = b[3:0];
        sub_eff = sub;
        c_in    = sub;
        if (state == RUN) begin
            wr_idx  = idx;
            dig_a   = a_q[4*int'(idx) +: 4];
            dig_b   = b_q[4*int'(idx) +: 4];
            sub_eff = sub_q;
            c_in    = c_q;
        end
    end

    always_comb begin
        dig_bp = sub_eff ? (4'd9 - dig_b) : dig_b;
        s      = {1'b0, dig_a} + {1'b0, dig_bp} + {4'b0000, c_in};
        s_fix  = s + 5'd6;
        if (s > 5'd9) begin
            dsum = s_fix[3:0];
            cout = 1'b1;
        end else begin
            dsum = s[3:0];
            cout = 1'b0;
        end
    end

    always_comb begin
        state_nx  = state;
        step      = 1'b0;
        fin       = 1'b0;
        bad_start = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (bad_ops) begin
                        bad_start = 1'b1;
                    end else begin
                        step = 1'b1;
                        if (DIGITS == 1) begin
                            fin = 1'b1;
                        end else begin
                            state_nx = RUN;
                        end
                    end
                end
            end
            RUN: begin
                step = 1'b1;
                if (idx == LAST) begin
                    fin      = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            sub_q  <= 1'b0;
            idx    <= '0;
            c_q    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            carry  <= 1'b0;
            err    <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            if (state == IDLE && start) begin
                a_q   <= a;
                b_q   <= b;
                sub_q <= sub;
                err   <= 1'b0;
            end
            if (bad_start) begin
                result <= '0;
                carry  <= 1'b0;
                err    <= 1'b1;
                done   <= 1'b1;
            end
            if (step) begin
                result[4*int'(wr_idx) +: 4] <= dsum;
                c_q <= cout;
                idx <= wr_idx + 1'b1;
            end
            if (state == IDLE && step && !fin) begin
                busy <= 1'b1;
            end
            // Subtraction is A + nines(B) + 1, so a missing final carry means a borrow.
            if (fin) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                carry <= sub_eff ? ~cout : cout;
            end
        end
    end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Scoreboard bench: directed BCD add/sub vectors on 4-, 1- and 8-digit instances, plus a decimal integer model for 8 digits.
module tb_bcd_serial_addsub;

    typedef struct {
        logic [31:0] r;
        logic        c;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        start_4 = 1'b0, sub_4 = 1'b0, busy_4, done_4, carry_4, err_4;
    logic [15:0] a_4 = '0, b_4 = '0, result_4;
    logic        start_1 = 1'b0, sub_1 = 1'b0, busy_1, done_1, carry_1, err_1;
    logic [3:0]  a_1 = '0, b_1 = '0, result_1;
    logic        start_8 = 1'b0, sub_8 = 1'b0, busy_8, done_8, carry_8, err_8;
    logic [31:0] a_8 = '0, b_8 = '0, result_8;

    exp_t q4[$];
    exp_t q1[$];
    exp_t q8[$];
    int   n_vec = 0;
    int   n_mis = 0;

    always #5 clk = ~clk;

    bcd_serial_addsub #(.DIGITS(4)) dut4 (
        .clk(clk), .reset(reset), .start(start_4), .sub(sub_4), .a(a_4), .b(b_4),
        .busy(busy_4), .done(done_4), .result(result_4), .carry(carry_4), .err(err_4));
    bcd_serial_addsub #(.DIGITS(1)) dut1 (
        .clk(clk), .reset(reset), .start(start_1), .sub(sub_1), .a(a_1), .b(b_1),
        .busy(busy_1), .done(done_1), .result(result_1), .carry(carry_1), .err(err_1));
    bcd_serial_addsub #(.DIGITS(8)) dut8 (
        .clk(clk), .reset(reset), .start(start_8), .sub(sub_8), .a(a_8), .b(b_8),
        .busy(busy_8), .done(done_8), .result(result_8), .carry(carry_8), .err(err_8));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic mon_cmp(input string tag, input logic [31:0] r, input logic c, input logic e,
                           inout exp_t q[$]);
        exp_t x;
        if (q.size() == 0) begin
            n_vec++;
            n_mis++;
            $display("FAIL %s_unexpected_done: got result %0h, expected no done", tag, r);
        end else begin
            x = q.pop_front();
            chk({tag, "_result"}, {32'h0, r}, {32'h0, x.r});
            chk({tag, "_carry"}, {63'h0, c}, {63'h0, x.c});
            chk({tag, "_err"}, {63'h0, e}, {63'h0, x.e});
        end
    endtask

    always @(negedge clk) if (!reset && done_4) mon_cmp("d4", {16'h0, result_4}, carry_4, err_4, q4);
    always @(negedge clk) if (!reset && done_1) mon_cmp("d1", {28'h0, result_1}, carry_1, err_1, q1);
    always @(negedge clk) if (!reset && done_8) mon_cmp("d8", result_8, carry_8, err_8, q8);

    function automatic longint bcd2int(input logic [31:0] v);
        longint n = 0;
        for (int i = 7; i >= 0; i--) n = n * 10 + longint'(v[4*i +: 4]);
        return n;
    endfunction

    function automatic logic [31:0] int2bcd(input longint n);
        logic [31:0] v = '0;
        longint      t = n;
        for (int i = 0; i < 8; i++) begin
            v[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return v;
    endfunction

    function automatic logic [31:0] rand_bcd8();
        logic [31:0] v;
        for (int i = 0; i < 8; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation on instance u, push the expectation, then time done and busy.
    task automatic op(input int u, input logic [31:0] av, input logic [31:0] bv, input logic s,
                      input logic [31:0] er, input logic ec, input logic ee,
                      input int exp_lat, input int exp_busy);
        exp_t e;
        int   lat = 0;
        int   bc = 0;
        logic got = 1'b0;
        e.r = er; e.c = ec; e.e = ee;
        case (u)
            1: begin q1.push_back(e); a_1 = av[3:0];  b_1 = bv[3:0];  sub_1 = s; start_1 = 1'b1; end
            8: begin q8.push_back(e); a_8 = av;       b_8 = bv;       sub_8 = s; start_8 = 1'b1; end
            default: begin q4.push_back(e); a_4 = av[15:0]; b_4 = bv[15:0]; sub_4 = s; start_4 = 1'b1; end
        endcase
        tick();
        start_1 = 1'b0; start_4 = 1'b0; start_8 = 1'b0;
        a_4 = 16'h9999; b_4 = 16'h9999; sub_4 = ~s;
        a_1 = 4'h9; b_1 = 4'h9; sub_1 = ~s;
        a_8 = rand_bcd8(); b_8 = rand_bcd8(); sub_8 = ~s;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            lat++;
            if ((u == 1 && busy_1) || (u == 8 && busy_8) || (u != 1 && u != 8 && busy_4)) bc++;
            if ((u == 1 && done_1) || (u == 8 && done_8) || (u != 1 && u != 8 && done_4)) got = 1'b1;
        end
        chk("done_seen", {63'h0, got}, 64'h1);
        chk("done_latency", 64'(lat), 64'(exp_lat));
        chk("busy_cycles", 64'(bc), 64'(exp_busy));
    endtask

    initial begin
        logic [31:0] ra, rb;
        longint      ia, ib, res;
        exp_t        e;
        int          got;

        tick(); tick();
        @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", {63'h0, busy_4}, 64'h0);
        chk("rst_done", {63'h0, done_4}, 64'h0);
        chk("rst_result", {48'h0, result_4}, 64'h0);
        chk("rst_carry", {63'h0, carry_4}, 64'h0);
        chk("rst_err", {63'h0, err_4}, 64'h0);
        tick();

        op(4, 32'h1234, 32'h5678, 1'b0, 32'h6912, 1'b0, 1'b0, 4, 3);
        op(4, 32'h9999, 32'h0001, 1'b0, 32'h0000, 1'b1, 1'b0, 4, 3);
        op(4, 32'h0999, 32'h0001, 1'b0, 32'h1000, 1'b0, 1'b0, 4, 3);
        op(4, 32'h5000, 32'h1234, 1'b1, 32'h3766, 1'b0, 1'b0, 4, 3);
        op(4, 32'h0001, 32'h0002, 1'b1, 32'h9999, 1'b1, 1'b0, 4, 3);
        op(4, 32'h12A4, 32'h0000, 1'b0, 32'h0000, 1'b0, 1'b1, 1, 0);
        op(4, 32'h0005, 32'h0004, 1'b0, 32'h0009, 1'b0, 1'b0, 4, 3);
        op(4, 32'h0000, 32'h00B0, 1'b1, 32'h0000, 1'b0, 1'b1, 1, 0);

        // A start pulse during RUN must be ignored entirely.
        e.r = 32'h3333; e.c = 1'b0; e.e = 1'b0;
        q4.push_back(e);
        a_4 = 16'h1111; b_4 = 16'h2222; sub_4 = 1'b0; start_4 = 1'b1;
        tick();
        start_4 = 1'b0;
        tick();
        a_4 = 16'h5555; b_4 = 16'h5555; start_4 = 1'b1;
        tick();
        start_4 = 1'b0;
        got = 0;
        for (int n = 0; n < 20 && got == 0; n++) begin
            @(negedge clk);
            if (done_4) got = 1;
        end
        chk("ignored_start_done", 64'(got), 64'h1);
        repeat (6) tick();
        chk("ignored_start_idle", {63'h0, busy_4}, 64'h0);

        // Reset mid-run: everything clears and no done follows.
        a_4 = 16'h1111; b_4 = 16'h2222; sub_4 = 1'b0; start_4 = 1'b1;
        tick();
        start_4 = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", {63'h0, busy_4}, 64'h0);
        chk("abort_done", {63'h0, done_4}, 64'h0);
        chk("abort_result", {48'h0, result_4}, 64'h0);
        chk("abort_carry", {63'h0, carry_4}, 64'h0);
        chk("abort_err", {63'h0, err_4}, 64'h0);
        repeat (6) tick();
        op(4, 32'h4321, 32'h1234, 1'b1, 32'h3087, 1'b0, 1'b0, 4, 3);

        op(1, 32'h7, 32'h8, 1'b0, 32'h5, 1'b1, 1'b0, 1, 0);
        op(1, 32'h3, 32'h5, 1'b1, 32'h8, 1'b1, 1'b0, 1, 0);
        op(1, 32'h9, 32'h4, 1'b1, 32'h5, 1'b0, 1'b0, 1, 0);

        op(8, 32'h99999999, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 8, 7);
        for (int k = 0; k < 12; k++) begin
            ra = rand_bcd8();
            rb = rand_bcd8();
            ia = bcd2int(ra);
            ib = bcd2int(rb);
            if (k[0]) begin
                res = ia - ib;
                if (res < 0) op(8, ra, rb, 1'b1, int2bcd(res + 100000000), 1'b1, 1'b0, 8, 7);
                else         op(8, ra, rb, 1'b1, int2bcd(res), 1'b0, 1'b0, 8, 7);
            end else begin
                res = ia + ib;
                op(8, ra, rb, 1'b0, int2bcd(res % 100000000), (res >= 100000000), 1'b0, 8, 7);
            end
        end

        repeat (4) tick();
        chk("q4_drained", 64'(q4.size()), 64'h0);
        chk("q1_drained", 64'(q1.size()), 64'h0);
        chk("q8_drained", 64'(q8.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
